exc_ctrl: RTL and testbench

- Exception/interrupt arbiter directly upstream of the CP0 register file.
- Collects instruction exceptions (syscall, break, teq) from the decoder, external interrupt lines and an internal compare timer.
- Each cycle produces the single `exception`/`cause` pair that CP0 consumes, gated by the CP0 `status` word fed back from CP0.
- Combinational to CP0 in the same cycle (single-cycle CPU). Pending/timer state is registered.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/irq_sync_edge.sv | 33 +++
 rtl/exc_ctrl.sv | 134 +++++++++++++
 tb/tb_exc_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_pkg
// Description : Cause codes and CP0 status bit positions for the exception
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BP  = 2;
    localparam int ST_TR  = 3;
    localparam int ST_INT = 4;

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Multi-flop synchronizer for one asynchronous level line,
//               followed by a single-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Exception/interrupt arbiter feeding CP0: instruction
//               exceptions, synchronized external IRQs and a compare timer.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               syscall,
    input  logic               brk,
    input  logic               teq_trap,
    input  logic               eret,
    input  logic               mtc0,
    input  logic [31:0]        status,
    input  logic [N_IRQ-1:0]   irq,
    input  logic               cmp_we,
    input  logic [TIMER_W-1:0] cmp_wdata,
    output logic               exception,
    output logic [4:0]         cause,
    output logic [3:0]         irq_id,
    output logic [N_IRQ:0]     irq_pending,
    output logic [TIMER_W-1:0] count
);

    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   r_pend;
    logic               r_tpend;
    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] r_cmp;
    logic [N_IRQ:0]     w_pend_all;
    logic               w_ie;
    logic               w_sys;
    logic               w_bp;
    logic               w_tr;
    logic               w_instr;
    logic               w_int_take;
    logic               w_match;
    logic [3:0]         w_low_id;
    logic [N_IRQ:0]     w_low_vec;
    logic [N_IRQ:0]     w_take_vec;
    logic               w_unused_status;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk     (clk),
                .rst     (rst),
                .i_async (irq[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_pend_all      = {r_tpend, r_pend};
    assign w_unused_status = &{1'b0, status[31:5]};

    assign w_ie    = status[ST_IE];
    assign w_sys   = w_ie & syscall  & status[ST_SYS];
    assign w_bp    = w_ie & brk      & status[ST_BP];
    assign w_tr    = w_ie & teq_trap & status[ST_TR];
    assign w_instr = w_sys | w_bp | w_tr;

    // Masked instruction exceptions do not block a pending interrupt.
    assign w_int_take = (|w_pend_all) & w_ie & status[ST_INT] & ~w_instr & ~eret & ~mtc0;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_low_id  = 4'd0;
        w_low_vec = '0;
        for (int i = N_IRQ; i >= 0; i--) begin
            if (w_pend_all[i]) begin
                w_low_id  = 4'(i);
                w_low_vec = (N_IRQ+1)'(1) << i;
            end
        end
    end

    assign w_take_vec = w_int_take ? w_low_vec : '0;

    always_comb begin
        exception = 1'b0;
        cause     = EXC_INT;
        irq_id    = 4'd0;
        if (w_sys) begin
            exception = 1'b1;
            cause     = EXC_SYS;
        end else if (w_bp) begin
            exception = 1'b1;
            cause     = EXC_BP;
        end else if (w_tr) begin
            exception = 1'b1;
            cause     = EXC_TR;
        end else if (w_int_take) begin
            exception = 1'b1;
            irq_id    = w_low_id;
        end
    end

    assign w_match = (r_count == r_cmp) && (r_cmp != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_tpend <= 1'b0;
            r_count <= '0;
            r_cmp   <= '0;
        end else begin
            // A fresh edge on the same edge as the take keeps the bit set.
            r_pend  <= w_rise | (r_pend & ~w_take_vec[N_IRQ-1:0]);
            r_count <= r_count + TIMER_W'(1);
            if (cmp_we) begin
                r_cmp   <= cmp_wdata;
                r_tpend <= 1'b0;
            end else begin
                r_tpend <= w_match | (r_tpend & ~w_take_vec[N_IRQ]);
            end
        end
    end

    assign irq_pending = w_pend_all;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Directed plus random stimulus for exc_ctrl against a delay-line
//               reference model of pending/timer behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exc_ctrl;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          syscall, brk, teq_trap, eret, mtc0;
    logic [31:0]   status;
    logic [N-1:0]  irq;
    logic          cmp_we;
    logic [TW-1:0] cmp_wdata;
    logic          exception;
    logic [4:0]    cause;
    logic [3:0]    irq_id;
    logic [N:0]    irq_pending;
    logic [TW-1:0] count;

    always #5 clk = ~clk;

    exc_ctrl #(
        .N_IRQ       (N),
        .SYNC_STAGES (S),
        .TIMER_W     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .syscall     (syscall),
        .brk         (brk),
        .teq_trap    (teq_trap),
        .eret        (eret),
        .mtc0        (mtc0),
        .status      (status),
        .irq         (irq),
        .cmp_we      (cmp_we),
        .cmp_wdata   (cmp_wdata),
        .exception   (exception),
        .cause       (cause),
        .irq_id      (irq_id),
        .irq_pending (irq_pending),
        .count       (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: irq samples history (index 0 = newest), pending, timer.
    logic [N-1:0]  m_hist [0:S];
    logic [N:0]    m_pend;
    logic [TW-1:0] m_count;
    logic [TW-1:0] m_cmp;
    logic          e_exc;
    logic          e_int;
    logic [4:0]    e_cause;
    logic [3:0]    e_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= S; k++) m_hist[k] = '0;
        m_pend  = '0;
        m_count = '0;
        m_cmp   = '0;
    endtask

    task automatic predict();
        e_exc = 1'b0; e_int = 1'b0; e_cause = 5'd0; e_id = 4'd0;
        if (status[0] && syscall && status[1]) begin
            e_exc = 1'b1; e_cause = 5'd8;
        end else if (status[0] && brk && status[2]) begin
            e_exc = 1'b1; e_cause = 5'd9;
        end else if (status[0] && teq_trap && status[3]) begin
            e_exc = 1'b1; e_cause = 5'd13;
        end else if (m_pend != 0 && status[0] && status[4] && !eret && !mtc0) begin
            e_exc = 1'b1; e_int = 1'b1;
            for (int i = 0; i <= N; i++) begin
                if (m_pend[i]) begin
                    e_id = 4'(i);
                    break;
                end
            end
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] edges;
        logic         hit;
        if (rst) begin
            model_reset();
        end else begin
            edges = m_hist[S-1] & ~m_hist[S];
            hit   = (m_count == m_cmp) && (m_cmp != 0);
            for (int i = 0; i < N; i++)
                if (e_int && e_id == 4'(i)) m_pend[i] = 1'b0;
            m_pend[N-1:0] = m_pend[N-1:0] | edges;
            if (cmp_we) begin
                m_pend[N] = 1'b0;
                m_cmp     = cmp_wdata;
            end else begin
                if (e_int && e_id == 4'(N)) m_pend[N] = 1'b0;
                if (hit) m_pend[N] = 1'b1;
            end
            m_count = m_count + 1'b1;
            for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = irq;
        end
    endtask

    task automatic step(input logic r, input logic sc, input logic bk, input logic tq,
                        input logic er, input logic mt, input logic [31:0] st,
                        input logic [N-1:0] iq, input logic cw, input logic [TW-1:0] cd);
        rst = r; syscall = sc; brk = bk; teq_trap = tq; eret = er; mtc0 = mt;
        status = st; irq = iq; cmp_we = cw; cmp_wdata = cd;
        #2;
        predict();
        chk("exception",   32'(exception),   32'(e_exc));
        chk("cause",       32'(cause),       32'(e_cause));
        chk("irq_id",      32'(irq_id),      32'(e_id));
        chk("irq_pending", 32'(irq_pending), 32'(m_pend));
        chk("count",       32'(count),       32'(m_count));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] st, input logic [N-1:0] iq);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, st, iq, 0, '0);
    endtask

    initial begin
        logic [N-1:0]  r_irq;
        logic [31:0]   r_st;
        logic [TW-1:0] r_cd;

        rst = 1'b1; syscall = 0; brk = 0; teq_trap = 0; eret = 0; mtc0 = 0;
        status = '0; irq = '0; cmp_we = 0; cmp_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        chk("reset_exception", 32'(exception),   32'd0);
        chk("reset_pending",   32'(irq_pending), 32'd0);
        chk("reset_count",     32'(count),       32'd0);

        // Instruction exceptions, enables and priority
        step(0, 1, 0, 0, 0, 0, 32'h1F, '0, 0, '0);
        step(0, 1, 0, 0, 0, 0, 32'h1D, '0, 0, '0);
        step(0, 1, 1, 1, 0, 0, 32'h0F, '0, 0, '0);
        step(0, 0, 1, 1, 0, 0, 32'h0F, '0, 0, '0);
        step(0, 0, 0, 1, 0, 0, 32'h0F, '0, 0, '0);
        step(0, 0, 0, 1, 0, 0, 32'h07, '0, 0, '0);
        step(0, 1, 0, 0, 1, 0, 32'h03, '0, 0, '0);

        // irq[2] rises, taken on the cycle its pending bit appears
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b0100, 0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b0100, 0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b0100, 0, '0);
        chk("irq2_pending", 32'(irq_pending[2]), 32'd1);
        chk("irq2_id",      32'(irq_id),         32'd2);
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b0100, 0, '0);
        chk("irq2_cleared", 32'(irq_pending[2]), 32'd0);
        idle(3, 32'h11, 4'b0100);

        // irq[1] and irq[3] pending, mtc0 defers take
        idle(4, 32'h00, 4'b1010);
        step(0, 0, 0, 0, 0, 1, 32'h11, 4'b1010, 0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b1010, 0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h11, 4'b1010, 0, '0);
        idle(2, 32'h11, 4'b0000);

        // Timer: compare=10 written at count 0 -> pending at count 11
        step(1, 0, 0, 0, 0, 0, 32'h0, '0, 0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h0, '0, 1, 8'd10);
        idle(10, 32'h0, '0);
        chk("timer_pending_at11", 32'(irq_pending[N]), 32'd1);
        chk("count_at11",         32'(count),          32'd11);
        step(0, 0, 0, 0, 0, 0, 32'h0, '0, 1, 8'd20);
        idle(8, 32'h0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h0, '0, 1, 8'd0);
        chk("timer_we_wins", 32'(irq_pending[N]), 32'd0);
        idle(260, 32'h0, '0);
        chk("timer_cmp0_never", 32'(irq_pending[N]), 32'd0);

        // Reset discards in-flight synchronizer bits and timer pending
        step(0, 0, 0, 0, 0, 0, 32'h0, '0, 1, m_count + 8'd2);
        idle(4, 32'h0, '0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 4'b0001, 0, '0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 4'b0001, 0, '0);
        chk("rst_pending", 32'(irq_pending), 32'd0);
        chk("rst_count",   32'(count),       32'd0);
        idle(5, 32'h11, '0);

        // Randomized traffic
        r_irq = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
            r_st    = $urandom;
            r_st[0] = ($urandom_range(0, 3) != 0);
            r_st[4] = ($urandom_range(0, 3) != 0);
            r_cd    = ($urandom_range(0, 4) == 0) ? '0 : m_count + TW'($urandom_range(1, 30));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 11) == 0), r_st, r_irq,
                 ($urandom_range(0, 19) == 0), r_cd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
